// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter for the shared VGA framebuffer write port.
// One drawer owns the port from grant until done, abort or hold watchdog.
//
// state   | meaning
// IDLE    | port free, pick next requester round-robin after last_owner
// OWN     | grant held, owner's pixel stream registered to the VGA outputs
// RELEASE | grant dropped, last_owner updated, back to IDLE next cycle
module draw_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int MAX_HOLD = 20000,
    parameter int HOLD_W   = 16,
    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [N_REQ*X_W-1:0] x_in,
    input  logic [N_REQ*Y_W-1:0] y_in,
    input  logic [N_REQ*C_W-1:0] colour_in,
    input  logic [N_REQ-1:0]     plot_in,
    output logic [N_REQ-1:0]     grant,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic                 timeout,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [C_W-1:0]       vga_colour,
    output logic                 vga_plot
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t             state, state_next;
    logic [OW-1:0]      last_owner;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [OW-1:0]      sel, cand;
    logic               found;
    logic               is_done, is_abort, wd_hit, leave;

    always_comb begin
        state_next = state;
        sel        = '0;
        cand       = '0;
        found      = 1'b0;
        is_done    = done[owner];
        is_abort   = !req[owner];
        wd_hit     = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        leave      = is_done || is_abort || wd_hit;

        // Scan upward from the requester after the last owner, wrapping.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(last_owner) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state)
            IDLE:    if (found) state_next = OWN;
            OWN:     if (leave) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            last_owner <= OW'(N_REQ - 1);
            hold_cnt   <= '0;
        end else begin
            state    <= state_next;
            timeout  <= 1'b0;
            vga_plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= ONE_HOT0 << sel;
                        owner    <= sel;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                OWN: begin
                    // The owner's final pixel is still written when done arrives with it.
                    vga_x      <= x_in[owner*X_W +: X_W];
                    vga_y      <= y_in[owner*Y_W +: Y_W];
                    vga_colour <= colour_in[owner*C_W +: C_W];
                    vga_plot   <= plot_in[owner];
                    hold_cnt   <= hold_cnt + 1'b1;
                    if (leave) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= wd_hit && !is_done;
                    end
                end
                RELEASE: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Self-checking bench for draw_port_arbiter: directed scenarios plus randomized
// bursts checked against a transaction-level round-robin/pixel model.
module tb_draw_port_arbiter;
    localparam int N = 4, XW = 8, YW = 7, CW = 3, MH = 8, HW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req, done, plot_in;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] colour_in;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic          busy, timeout;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    int checks = 0;
    int failures = 0;
    int m_last;

    draw_port_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                        .MAX_HOLD(MH), .HOLD_W(HW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
        .grant(grant), .owner(owner), .busy(busy), .timeout(timeout),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; done = '0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({grant, owner, busy, timeout, vga_x, vga_y, vga_colour, vga_plot} !== '0) begin
            failures++;
            $display("FAIL reset_outputs grant=%b owner=%0d busy=%b timeout=%b x=%0d y=%0d c=%0d plot=%b required all zero",
                     grant, owner, busy, timeout, vga_x, vga_y, vga_colour, vga_plot);
        end
        resetn = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant grant=%b busy=%b required 0001/1", grant, busy);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_single_burst();
        logic [XW-1:0] xs [2];
        xs[0] = 8'd10; xs[1] = 8'd11;
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            failures++;
            $display("FAIL burst_grant grant=%b owner=%0d required 0010/1", grant, owner);
        end
        for (int p = 0; p < 2; p++) begin
            plot_in = 4'b0010;
            x_in[1*XW +: XW] = xs[p];
            y_in[1*YW +: YW] = 7'd20;
            colour_in[1*CW +: CW] = 3'd3;
            tick();
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== xs[p] || vga_y !== 7'd20 || vga_colour !== 3'd3) begin
                failures++;
                $display("FAIL burst_pixel%0d plot=%b x=%0d y=%0d c=%0d required 1/%0d/20/3",
                         p, vga_plot, vga_x, vga_y, vga_colour, xs[p]);
            end
        end
        plot_in = '0;
        done = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0000 || vga_plot !== 1'b0) begin
            failures++;
            $display("FAIL burst_release grant=%b plot=%b required 0000/0", grant, vga_plot);
        end
        clear_inputs();
        tick();
        checks++;
        if (vga_plot !== 1'b0 || vga_x !== 8'd11) begin
            failures++;
            $display("FAIL burst_after plot=%b x=%0d required 0/11", vga_plot, vga_x);
        end
    endtask

    task automatic test_rotation();
        int gap;
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (grant !== (4'b0001 << (g % N))) begin
                failures++;
                $display("FAIL rotation_order%0d grant=%b required %b", g, grant, 4'b0001 << (g % N));
            end
            tick();
            tick();
            done = grant;
            tick();
            done = '0;
            gap = 1;
            while (grant === '0 && gap < 10) begin
                tick();
                if (grant === '0) gap++;
            end
            if (g < 4) begin
                checks++;
                if (gap !== 2) begin
                    failures++;
                    $display("FAIL rotation_gap%0d gap=%0d required 2", g, gap);
                end
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_non_owner_isolation();
        logic [XW-1:0] ex;
        logic          ep;
        do_reset();
        req = 4'b0101;
        tick();
        for (int c = 0; c < 4; c++) begin
            ep = 1'($urandom_range(0, 1));
            ex = 8'($urandom_range(0, 127));
            plot_in = {1'b0, 1'b1, 1'b0, ep};
            done = 4'b0100;
            x_in[0 +: XW] = ex;
            x_in[2*XW +: XW] = 8'd200 + 8'(c);
            tick();
            checks++;
            if (vga_plot !== ep || vga_x !== ex || grant !== 4'b0001) begin
                failures++;
                $display("FAIL isolation%0d plot=%b x=%0d grant=%b required %b/%0d/0001",
                         c, vga_plot, vga_x, grant, ep, ex);
            end
        end
        plot_in = '0;
        done = 4'b0001;
        tick();
        done = '0;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL isolation_next grant=%b required 0100", grant);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int held;
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        held = 0;
        while (grant === 4'b1000 && held < 20) begin
            held++;
            tick();
        end
        checks++;
        if (held !== MH) begin
            failures++;
            $display("FAIL watchdog_hold held=%0d required %0d", held, MH);
        end
        checks++;
        if (timeout !== 1'b1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL watchdog_pulse timeout=%b grant=%b required 1/0000", timeout, grant);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_pulse_width timeout=%b required 0", timeout);
        end
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL watchdog_next grant=%b required 0001", grant);
        end
        // Done on the watchdog cycle is a normal end.
        do_reset();
        req = 4'b1000;
        tick();
        for (int c = 1; c < MH; c++) tick();
        done = 4'b1000;
        tick();
        done = '0;
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_done_tie grant=%b timeout=%b required 0000/0", grant, timeout);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0100;
        tick();
        plot_in = 4'b0100;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (vga_plot !== 1'b1 || grant !== 4'b0100) begin
            failures++;
            $display("FAIL midreset_pre plot=%b grant=%b required 1/0100", vga_plot, grant);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (vga_plot !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear plot=%b grant=%b busy=%b required 0/0000/0", vga_plot, grant, busy);
        end
        resetn = 1'b1;
        plot_in = '0;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_next grant=%b required 0001", grant);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random_bursts();
        logic [N-1:0]  mask;
        int            w, len, waited;
        logic          ep;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            mask = 4'($urandom_range(1, 15));
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && mask[(m_last + k) % N]) w = (m_last + k) % N;
            req = mask;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (grant === '0 && waited < 4);
            checks++;
            if (grant !== (4'b0001 << w) || owner !== 2'(w) || busy !== 1'b1) begin
                failures++;
                $display("FAIL rand_grant%0d grant=%b owner=%0d busy=%b required %b/%0d/1",
                         t, grant, owner, busy, 4'b0001 << w, w);
            end
            len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                x_in = $urandom;
                y_in = 28'($urandom);
                colour_in = 12'($urandom);
                plot_in = 4'($urandom);
                done = 4'($urandom) & ~(4'b0001 << w);
                if (c == len - 1) done[w] = 1'b1;
                ep = plot_in[w];
                ex = x_in[w*XW +: XW];
                ey = y_in[w*YW +: YW];
                ec = colour_in[w*CW +: CW];
                tick();
                checks++;
                if (vga_plot !== ep || vga_x !== ex || vga_y !== ey || vga_colour !== ec) begin
                    failures++;
                    $display("FAIL rand_pixel%0d_%0d plot=%b x=%0d y=%0d c=%0d required %b/%0d/%0d/%0d",
                             t, c, vga_plot, vga_x, vga_y, vga_colour, ep, ex, ey, ec);
                end
                checks++;
                if (grant !== ((c == len - 1) ? 4'b0000 : (4'b0001 << w))) begin
                    failures++;
                    $display("FAIL rand_hold%0d_%0d grant=%b cycle=%0d of %0d", t, c, grant, c, len);
                end
            end
            clear_inputs();
            tick();
            checks++;
            if (vga_plot !== 1'b0 || grant !== 4'b0000) begin
                failures++;
                $display("FAIL rand_idle%0d plot=%b grant=%b required 0/0000", t, vga_plot, grant);
            end
            m_last = w;
        end
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        m_last = N - 1;
        test_reset();
        test_single_burst();
        test_rotation();
        test_non_owner_isolation();
        test_watchdog();
        test_reset_mid_burst();
        test_random_bursts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end
endmodule
